// File: rtl/ecp5_pll_pkg.sv
// Shared types and constants for the ECP5 PLL dynamic phase-shift controller.
package ecp5_pll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam logic [1:0] SEL_CLKOP  = 2'd0;
    localparam logic [1:0] SEL_CLKOS  = 2'd1;
    localparam logic [1:0] SEL_CLKOS2 = 2'd2;
    localparam logic [1:0] SEL_CLKOS3 = 2'd3;

    localparam logic PHASESTEP_IDLE = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Two-flop synchroniser for the raw PLL lock followed by a saturating
// consecutive-high counter; locked falls on the first synchronised low.
module pll_lock_filter
    import ecp5_pll_pkg::*;
#(
    parameter int LOCK_FILTER = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_lock,
    output logic locked
);

    localparam int CW = clog2(LOCK_FILTER + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_FILTER);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= pll_lock;
            sync2 <= sync1;
            if (!sync2)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    assign locked = sync2 && (cnt == CNT_MAX);

endmodule

// File: rtl/ecp5_pll_dphase_ctlr.sv
// Sequences EHXPLLL PHASESEL/PHASEDIR/PHASESTEP to shift one PLL output by
// N fine steps per request, and tracks each output's phase position.
module ecp5_pll_dphase_ctlr
    import ecp5_pll_pkg::*;
#(
    parameter int NUM_OUT       = 4,
    parameter int STEP_W        = 8,
    parameter int PHASE_MOD     = 24,
    parameter int SETUP_CYCLES  = 2,
    parameter int PULSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int LOCK_FILTER   = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      pll_lock,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [1:0]                                req_sel,
    input  logic                                      req_dir,
    input  logic [STEP_W-1:0]                         req_steps,
    output logic                                      done,
    output logic                                      err,
    output logic                                      busy,
    output logic                                      locked,
    output logic [1:0]                                phasesel,
    output logic                                      phasedir,
    output logic                                      phasestep,
    output logic [NUM_OUT*clog2(PHASE_MOD)-1:0]       phase_pos
);

    localparam int PHW  = clog2(PHASE_MOD);
    localparam int TMAX = (SETUP_CYCLES > PULSE_CYCLES)
                          ? ((SETUP_CYCLES > SETTLE_CYCLES) ? SETUP_CYCLES : SETTLE_CYCLES)
                          : ((PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES);
    localparam int TW   = clog2(TMAX + 1);
    localparam logic [2:0]     NUM_OUT_W = 3'(NUM_OUT);
    localparam logic [PHW-1:0] POS_TOP   = PHW'(PHASE_MOD - 1);

    state_t            state, state_nxt;
    logic [TW-1:0]     tmr, tmr_nxt;
    logic [STEP_W-1:0] rem, rem_nxt;
    logic [1:0]        sel_q;
    logic              dir_q;
    logic              err_q, err_nxt;
    logic              step;
    logic              accept;
    logic [PHW-1:0]    pos [NUM_OUT];

    pll_lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_lock (
        .clk      (clk),
        .rst      (rst),
        .pll_lock (pll_lock),
        .locked   (locked)
    );

    assign req_ready = locked && (state == ST_IDLE);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            tmr   <= '0;
            rem   <= '0;
            sel_q <= SEL_CLKOP;
            dir_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            rem   <= rem_nxt;
            err_q <= err_nxt;
            if (accept) begin
                sel_q <= req_sel;
                dir_q <= req_dir;
            end
        end
    end

    // Lock loss aborts from any active state; the step in flight is not counted.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = (tmr != '0) ? tmr - 1'b1 : tmr;
        rem_nxt   = rem;
        step      = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    rem_nxt = req_steps;
                    if ({1'b0, req_sel} >= NUM_OUT_W) begin
                        state_nxt = ST_DONE;
                        err_nxt   = 1'b1;
                    end else if (req_steps == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_SETUP;
                        tmr_nxt   = TW'(SETUP_CYCLES - 1);
                    end
                end
            end
            ST_SETUP: begin
                if (!locked) begin
                    state_nxt = ST_DONE;
                    err_nxt   = 1'b1;
                end else if (tmr == '0) begin
                    state_nxt = ST_PULSE;
                    tmr_nxt   = TW'(PULSE_CYCLES - 1);
                end
            end
            ST_PULSE: begin
                if (!locked) begin
                    state_nxt = ST_DONE;
                    err_nxt   = 1'b1;
                end else if (tmr == '0) begin
                    state_nxt = ST_SETTLE;
                    tmr_nxt   = TW'(SETTLE_CYCLES - 1);
                    step      = 1'b1;
                    rem_nxt   = rem - 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!locked) begin
                    state_nxt = ST_DONE;
                    err_nxt   = 1'b1;
                end else if (tmr == '0) begin
                    if (rem == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_PULSE;
                        tmr_nxt   = TW'(PULSE_CYCLES - 1);
                    end
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The PLL relocks at its static phases, so positions are void while unlocked.
    always_ff @(posedge clk) begin
        if (rst || !locked) begin
            for (int i = 0; i < NUM_OUT; i++) pos[i] <= '0;
        end else if (step) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (sel_q == 2'(i)) begin
                    if (dir_q)
                        pos[i] <= (pos[i] == POS_TOP) ? '0 : pos[i] + 1'b1;
                    else
                        pos[i] <= (pos[i] == '0) ? POS_TOP : pos[i] - 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_pos
        assign phase_pos[g*PHW +: PHW] = pos[g];
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign err       = (state == ST_DONE) && err_q;
    assign phasesel  = busy ? sel_q : 2'd0;
    assign phasedir  = busy ? dir_q : 1'b0;
    assign phasestep = (state == ST_PULSE) ? ~PHASESTEP_IDLE : PHASESTEP_IDLE;

endmodule

// File: tb/tb_ecp5_pll_dphase_ctlr.sv
// Randomised bench for ecp5_pll_dphase_ctlr (three outputs, default timing)
// against a position/latency model derived from the phase-step rules.
module tb_ecp5_pll_dphase_ctlr;

    localparam int NOUT = 3;
    localparam int PHW  = 5;
    localparam int MOD  = 24;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  pll_lock;
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_sel;
    logic                  req_dir;
    logic [7:0]            req_steps;
    logic                  done;
    logic                  err;
    logic                  busy;
    logic                  locked;
    logic [1:0]            phasesel;
    logic                  phasedir;
    logic                  phasestep;
    logic [NOUT*PHW-1:0]   phase_pos;

    int n_chk = 0;
    int n_err = 0;
    int pos_m [NOUT];

    ecp5_pll_dphase_ctlr #(.NUM_OUT(NOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_dir   (req_dir),
        .req_steps (req_steps),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .locked    (locked),
        .phasesel  (phasesel),
        .phasedir  (phasedir),
        .phasestep (phasestep),
        .phase_pos (phase_pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_positions(input string tag);
        for (int i = 0; i < NOUT; i++)
            chk(tag, 32'(phase_pos[i*PHW +: PHW]), 32'(pos_m[i]));
    endtask

    task automatic clear_model();
        for (int i = 0; i < NOUT; i++) pos_m[i] = 0;
    endtask

    // Waits for ready, presents one request, returns just after the accept edge.
    task automatic start_req(input int sel, input int dir, input int steps);
        int w;
        w = 0;
        while (!req_ready && w < 100) begin
            tick();
            w++;
        end
        if (!req_ready) chk("ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_sel   = 2'(sel);
        req_dir   = 1'(dir);
        req_steps = 8'(steps);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_req(input int sel, input int dir, input int steps);
        int c, lows, pulses, run, exp_lat, n_exp;
        logic prev, badw, selbad, rdybad, isbad;
        isbad = (sel >= NOUT);
        n_exp = isbad ? 0 : steps;
        exp_lat = (n_exp == 0) ? 1 : 2 + 8 * n_exp + 1;
        start_req(sel, dir, steps);
        c = 1; lows = 0; pulses = 0; run = 0;
        prev = 1'b1; badw = 1'b0; selbad = 1'b0; rdybad = 1'b0;
        while (done !== 1'b1 && c < 400) begin
            if (phasestep === 1'b0) begin
                lows++;
                run++;
                if (prev) pulses++;
            end else begin
                if (!prev && run != 4) badw = 1'b1;
                run = 0;
            end
            prev = phasestep;
            if (phasesel !== 2'(sel) || phasedir !== 1'(dir) || busy !== 1'b1) selbad = 1'b1;
            if (req_ready !== 1'b0) rdybad = 1'b1;
            req_valid = 1'($urandom_range(0, 1));
            req_sel   = 2'($urandom_range(0, 3));
            req_dir   = 1'($urandom_range(0, 1));
            req_steps = 8'($urandom_range(0, 9));
            tick();
            c++;
        end
        req_valid = 1'b0;
        if (!prev && run != 4) badw = 1'b1;
        chk("latency", 32'(c), 32'(exp_lat));
        chk("done", 32'(done), 32'd1);
        chk("err", 32'(err), 32'(isbad));
        chk("step_hi_done", 32'(phasestep), 32'd1);
        chk("pulses", 32'(pulses), 32'(n_exp));
        chk("low_cycles", 32'(lows), 32'(4 * n_exp));
        chk("pulse_width", 32'(badw), 32'd0);
        chk("sel_dir_hold", 32'(selbad), 32'd0);
        chk("ready_busy", 32'(rdybad), 32'd0);
        if (!isbad) begin
            if (dir != 0) pos_m[sel] = (pos_m[sel] + steps % MOD) % MOD;
            else          pos_m[sel] = (pos_m[sel] + MOD - steps % MOD) % MOD;
        end
        check_positions("pos");
        tick();
        chk("idle_after", 32'({busy, done, err}), 32'd0);
    endtask

    initial begin
        int k;
        logic prev;
        int pulses;
        clear_model();
        rst = 1'b1; pll_lock = 1'b0; req_valid = 1'b0;
        req_sel = '0; req_dir = 1'b0; req_steps = '0;
        repeat (3) tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_step", 32'(phasestep), 32'd1);
        chk("rst_seldir", 32'({phasesel, phasedir}), 32'd0);
        chk("rst_pos", 32'(phase_pos), 32'd0);

        rst = 1'b0; pll_lock = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!locked && k < 100);
        chk("lock_latency", 32'(k), 32'd18);
        chk("ready_on_lock", 32'(req_ready), 32'd1);

        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        chk("lock_hold", 32'(locked), 32'd1);
        tick();
        chk("lock_drop", 32'(locked), 32'd0);
        k = 2;
        do begin tick(); k++; end while (!locked && k < 100);
        chk("relock_latency", 32'(k), 32'd19);

        do_req(1, 1, 3);
        do_req(2, 0, 1);
        do_req(2, 1, 25);
        do_req(0, 1, 0);
        do_req(3, 1, 5);
        for (int i = 0; i < 12; i++)
            do_req($urandom_range(0, 3), $urandom_range(0, 1),
                   ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 30));

        // Lock loss during the second pulse of a five-step request.
        do_req(0, 1, 7);
        start_req(1, 1, 5);
        pulses = 0; prev = 1'b1; k = 0;
        while (pulses < 2 && k < 200) begin
            if (!phasestep && prev) pulses++;
            prev = phasestep;
            if (pulses < 2) begin tick(); k++; end
        end
        chk("abort_reach", 32'(pulses), 32'd2);
        pll_lock = 1'b0;
        tick();
        tick();
        chk("abort_still_low", 32'(phasestep), 32'd0);
        tick();
        chk("abort_step_hi", 32'(phasestep), 32'd1);
        chk("abort_done_err", 32'({done, err}), 32'd3);
        clear_model();
        chk("abort_pos", 32'(phase_pos), 32'd0);
        pll_lock = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!req_ready && k < 100);
        chk("abort_relock", 32'(k), 32'd18);
        do_req(2, 0, 2);

        // Synchronous reset in the middle of a pulse.
        start_req(1, 1, 3);
        k = 0;
        while (phasestep && k < 100) begin tick(); k++; end
        chk("rst_reach_pulse", 32'(phasestep), 32'd0);
        rst = 1'b1;
        tick();
        chk("midrst_step", 32'(phasestep), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pos", 32'(phase_pos), 32'd0);
        rst = 1'b0;
        clear_model();
        do_req(1, 0, 2);
        do_req(0, 1, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
